instruction_fetch_unit: RTL and testbench

Parametrised instruction fetch stage that replaces the single-entry fetch/memory block. It owns the fetch PC, a synchronous-read instruction RAM and a small prefetch queue, and presents one tagged instruction per cycle to decode. It adds three things the previous block lacks:
- flush-with-redirect that squashes in-flight reads;
- credit-based prefetch that never drops an instruction on stall;
- a program-load mode with its own write port.

---
 rtl/instruction_fetch_unit_pkg.sv | 24 ++
 rtl/instruction_fetch_unit_fetch_queue.sv | 77 +++++++
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: pipeline control enums and the
// queue entry layout carried from the instruction RAM to decode.
package instruction_fetch_unit_pkg;

    localparam int WORD      = 32;
    localparam int HALF_WORD = 16;

    typedef enum logic {
        NO_FLUSH       = 1'b0,
        FLUSH_PIPELINE = 1'b1
    } flush_pipeline_sig;

    typedef enum logic {
        NO_STALL = 1'b0,
        STALL    = 1'b1
    } stall_pipeline_sig;

    // Sized for the widest supported configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [HALF_WORD-1:0] instr;
        logic [WORD-1:0]      pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch FIFO between the instruction RAM and decode. Clear empties it in one
// cycle and takes priority over a simultaneous push or pop.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push  = push_i && !clear_i;
        do_pop   = pop_i && !clear_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: fetch PC, synchronous instruction RAM with a program
// load port, and a credit-limited prefetch queue feeding decode one entry per cycle.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 9,
    parameter int PC_W        = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               load_en_i,
    input  logic [ADDR_W-1:0]                  load_addr_i,
    input  logic [INSTR_W-1:0]                 load_data_i,
    input  flush_pipeline_sig                  flush_pipeline_i,
    input  logic [PC_W-1:0]                    redirect_addr_i,
    input  stall_pipeline_sig                  stall_pipeline_i,
    output logic                               valid_o,
    output logic [INSTR_W-1:0]                 instruction_o,
    output logic [PC_W-1:0]                    pc_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   occupancy_o
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    if (QUEUE_DEPTH < 3) begin : g_depth_check
        $error("instruction_fetch_unit: QUEUE_DEPTH must be at least 3");
    end
    if (INSTR_W > HALF_WORD || PC_W > WORD) begin : g_width_check
        $error("instruction_fetch_unit: INSTR_W/PC_W exceed fetch_entry_t fields");
    end

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               epoch_q, epoch_d;
    logic               rd_vld_q, rd_vld_d;
    logic               rd_epoch_q, rd_epoch_d;
    logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
    logic [INSTR_W-1:0] last_instr_q, last_instr_d;
    logic [PC_W-1:0]    last_pc_q, last_pc_d;
    logic [INSTR_W-1:0] ram_rdata;

    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;
    logic               flush, issue, push, pop, has_head;
    fetch_entry_t       push_entry, head;

    always_comb begin
        flush    = (flush_pipeline_i == FLUSH_PIPELINE);
        has_head = (count != '0);

        // Queued entries plus the read still in the RAM pipe must fit the queue.
        credit_used = {1'b0, count} + {{CNT_W{1'b0}}, rd_vld_q};
        issue       = reset_n_i && !load_en_i && (credit_used < (CNT_W+1)'(QUEUE_DEPTH));

        fetch_pc_d = fetch_pc_q;
        if (flush) begin
            fetch_pc_d = redirect_addr_i;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
        end

        // Toggling the epoch orphans the read issued before or during the flush.
        epoch_d    = flush ? ~epoch_q : epoch_q;
        rd_vld_d   = issue;
        rd_epoch_d = issue ? epoch_q : rd_epoch_q;
        rd_pc_d    = issue ? fetch_pc_q : rd_pc_q;

        push = rd_vld_q && (rd_epoch_q == epoch_q);
        pop  = has_head && (stall_pipeline_i != STALL);

        push_entry                    = '0;
        push_entry.instr[INSTR_W-1:0] = ram_rdata;
        push_entry.pc[PC_W-1:0]       = rd_pc_q;

        last_instr_d = last_instr_q;
        last_pc_d    = last_pc_q;
        if (has_head) begin
            last_instr_d = head.instr[INSTR_W-1:0];
            last_pc_d    = head.pc[PC_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_epoch_q   <= 1'b0;
            rd_pc_q      <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            epoch_q      <= epoch_d;
            rd_vld_q     <= rd_vld_d;
            rd_epoch_q   <= rd_epoch_d;
            rd_pc_q      <= rd_pc_d;
            last_instr_q <= last_instr_d;
            last_pc_q    <= last_pc_d;
        end
    end

`ifdef DC
    ifu_imem_macro #(
        .DATA_W (INSTR_W),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk_i   (clk_i),
        .we_i    (load_en_i),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .re_i    (issue),
        .raddr_i (fetch_pc_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );
`else
    logic [INSTR_W-1:0] imem_q [2**ADDR_W];

    // Contents survive reset; upper PC bits alias onto the same index.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            imem_q[load_addr_i] <= load_data_i;
        end
        if (issue) begin
            ram_rdata <= imem_q[fetch_pc_q[ADDR_W-1:0]];
        end
    end
`endif

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .clear_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    assign valid_o       = has_head;
    assign instruction_o = has_head ? head.instr[INSTR_W-1:0] : last_instr_q;
    assign pc_o          = has_head ? head.pc[PC_W-1:0] : last_pc_q;
    assign occupancy_o   = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random
// stall/flush/load/reset traffic against a queue-based reference model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 9;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 4;
    localparam int RAM_N   = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [INSTR_W-1:0] load_data;
    flush_pipeline_sig flush_sig;
    logic [PC_W-1:0]   redirect;
    stall_pipeline_sig stall_sig;
    logic              valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]   pc;
    logic [2:0]        occ;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(
        .INSTR_W     (INSTR_W),
        .ADDR_W      (ADDR_W),
        .PC_W        (PC_W),
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    ('0)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data),
        .flush_pipeline_i (flush_sig),
        .redirect_addr_i  (redirect),
        .stall_pipeline_i (stall_sig),
        .valid_o          (valid),
        .instruction_o    (instr),
        .pc_o             (pc),
        .occupancy_o      (occ)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        bit                 live;
        int                 due;
    } flight_t;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    logic [INSTR_W-1:0] img [RAM_N];
    flight_t            flight_q[$];
    ent_t               vis_q[$];
    logic [PC_W-1:0]    m_pc;
    logic [PC_W-1:0]    last_pc;
    logic [INSTR_W-1:0] last_instr;
    int                 edge_n = 0;

    // One clock edge: every fetch reaches decode two edges after it was issued,
    // unless a flush in between has squashed it.
    task automatic model_step();
        bit      do_issue, do_pop, do_flush;
        flight_t f;
        edge_n++;
        if (!reset_n) begin
            vis_q.delete();
            flight_q.delete();
            m_pc       = '0;
            last_pc    = '0;
            last_instr = '0;
            if (load_en) img[load_addr] = load_data;
            return;
        end
        do_issue = !load_en && ((vis_q.size() + flight_q.size()) < DEPTH);
        do_pop   = (vis_q.size() > 0) && (stall_sig != STALL);
        do_flush = (flush_sig == FLUSH_PIPELINE);
        if (vis_q.size() > 0) begin
            last_pc    = vis_q[0].pc;
            last_instr = vis_q[0].instr;
        end
        if (do_pop) void'(vis_q.pop_front());
        while (flight_q.size() > 0 && flight_q[0].due == edge_n) begin
            f = flight_q.pop_front();
            if (f.live) vis_q.push_back('{pc: f.pc, instr: f.instr});
        end
        if (do_flush) begin
            vis_q.delete();
            foreach (flight_q[i]) flight_q[i].live = 1'b0;
        end
        if (do_issue) begin
            flight_q.push_back('{pc: m_pc, instr: img[m_pc[ADDR_W-1:0]],
                                 live: !do_flush, due: edge_n + 1});
        end
        if (load_en) img[load_addr] = load_data;
        if (do_flush)      m_pc = redirect;
        else if (do_issue) m_pc = m_pc + 32'd1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [PC_W-1:0]    e_pc;
        logic [INSTR_W-1:0] e_instr;
        if (vis_q.size() > 0) begin
            e_pc    = vis_q[0].pc;
            e_instr = vis_q[0].instr;
        end else begin
            e_pc    = last_pc;
            e_instr = last_instr;
        end
        check_eq("valid", 32'(valid), 32'(vis_q.size() != 0));
        check_eq("pc", pc, e_pc);
        check_eq("instr", 32'(instr), 32'(e_instr));
        check_eq("occupancy", 32'(occ), 32'(vis_q.size()));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic flush_to(input logic [PC_W-1:0] addr);
        flush_sig = FLUSH_PIPELINE;
        redirect  = addr;
        tick();
        flush_sig = NO_FLUSH;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int              n;
        logic [PC_W-1:0] r;

        reset_n   = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        flush_sig = NO_FLUSH;
        redirect  = '0;
        stall_sig = NO_STALL;
        m_pc      = '0;

        repeat (2) tick();
        check_eq("reset_valid", 32'(valid), 32'd0);
        check_eq("reset_occ", 32'(occ), 32'd0);
        check_eq("reset_pc", pc, 32'd0);

        // Program the whole RAM; the first eight words form a recognisable run.
        reset_n = 1'b1;
        load_en = 1'b1;
        for (int a = 0; a < RAM_N; a++) begin
            load_addr = ADDR_W'(a);
            load_data = (a < 8) ? INSTR_W'(16'h1000 + a) : INSTR_W'($urandom);
            tick();
        end
        load_en = 1'b0;

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        while (!valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("first_valid_cycle", 32'(n + 1), 32'd3);
        for (int i = 0; i < 8; i++) begin
            check_eq("seq_pc", pc, 32'(i));
            check_eq("seq_instr", 32'(instr), 32'(16'h1000 + i));
            tick();
        end

        stall_sig = STALL;
        repeat (10) tick();
        check_eq("stall_occ_sat", 32'(occ), 32'(DEPTH));
        stall_sig = NO_STALL;
        repeat (6) tick();

        // Flush with three queued and one read in flight.
        stall_sig = STALL;
        repeat (6) tick();
        stall_sig = NO_STALL;
        tick();
        stall_sig = STALL;
        tick();
        check_eq("pre_flush_occ", 32'(occ), 32'd3);
        flush_to(32'd5);
        stall_sig = NO_STALL;
        check_eq("flush_valid_c1", 32'(valid), 32'd0);
        tick();
        check_eq("flush_valid_c2", 32'(valid), 32'd0);
        tick();
        check_eq("flush_valid_c3", 32'(valid), 32'd1);
        check_eq("flush_pc_c3", pc, 32'd5);

        // Flush while popping, while stalled, and onto an already-empty queue.
        for (int p = 0; p < 3; p++) begin
            stall_sig = NO_STALL;
            repeat (4) tick();
            r = 32'(100 + p * 17);
            stall_sig = (p == 1) ? STALL : NO_STALL;
            if (p == 2) begin
                flush_to(r);
                r = r + 32'd3;
            end
            flush_to(r);
            check_eq("perm_valid_c1", 32'(valid), 32'd0);
            check_eq("perm_occ_c1", 32'(occ), 32'd0);
            stall_sig = NO_STALL;
            repeat (2) tick();
            check_eq("perm_valid_c3", 32'(valid), 32'd1);
            check_eq("perm_pc_c3", pc, r);
        end

        repeat (3) tick();
        load_en   = 1'b1;
        load_addr = 9'd3;
        load_data = 16'hBEEF;
        tick();
        load_en = 1'b0;
        flush_to(32'd3);
        repeat (2) tick();
        check_eq("load_pc", pc, 32'd3);
        check_eq("load_instr", 32'(instr), 32'h0000_BEEF);

        // Load and redirect in the same cycle both take effect.
        load_en   = 1'b1;
        load_addr = 9'd9;
        load_data = 16'hA5A5;
        flush_sig = FLUSH_PIPELINE;
        redirect  = 32'd9;
        tick();
        load_en   = 1'b0;
        flush_sig = NO_FLUSH;
        repeat (2) tick();
        check_eq("load_flush_pc", pc, 32'd9);
        check_eq("load_flush_instr", 32'(instr), 32'h0000_A5A5);

        stall_sig = STALL;
        repeat (6) tick();
        check_eq("pre_reset_occ", 32'(occ), 32'(DEPTH));
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        stall_sig = NO_STALL;
        check_eq("midreset_valid", 32'(valid), 32'd0);
        check_eq("midreset_occ", 32'(occ), 32'd0);
        repeat (2) tick();
        check_eq("restart_valid", 32'(valid), 32'd1);
        check_eq("restart_pc", pc, 32'd0);
        check_eq("restart_instr", 32'(instr), 32'h0000_1000);

        flush_to(32'hFFFF_FFFE);
        repeat (2) tick();
        check_eq("wrap_pc0", pc, 32'hFFFF_FFFE);
        tick();
        check_eq("wrap_pc1", pc, 32'hFFFF_FFFF);
        tick();
        check_eq("wrap_pc2", pc, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            stall_sig = ($urandom_range(0, 99) < 30) ? STALL : NO_STALL;
            if ($urandom_range(0, 99) < 5) begin
                flush_sig = FLUSH_PIPELINE;
                case ($urandom_range(0, 2))
                    0:       redirect = $urandom;
                    1:       redirect = 32'hFFFF_FFFF - $urandom_range(0, 3);
                    default: redirect = $urandom_range(0, RAM_N - 1);
                endcase
            end else begin
                flush_sig = NO_FLUSH;
            end
            load_en   = ($urandom_range(0, 99) < 5);
            load_addr = ADDR_W'($urandom_range(0, RAM_N - 1));
            load_data = INSTR_W'($urandom);
            tick();
        end

        reset_n   = 1'b1;
        load_en   = 1'b0;
        flush_sig = NO_FLUSH;
        stall_sig = NO_STALL;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
